// File: rtl/stack.sv
// Synchronous LIFO operand stack with a directly visible top-of-stack word.
// One op (none/push/pop/replace) per clock, with per-op underflow/overflow reporting.
module stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] tos,
    output logic [1:0]       status,
    output logic [1:0]       error
);
    localparam int MAX = (1 << (DEPTH + 1)) - 1;
    localparam int CW  = DEPTH + 2;
    localparam int AW  = DEPTH + 1;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_EMPTY = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam logic [1:0] ER_NONE      = 2'b00;
    localparam logic [1:0] ER_UNDERFLOW = 2'b01;
    localparam logic [1:0] ER_OVERFLOW  = 2'b10;

    // Initializers give an EMPTY stack at power-on even before reset is applied.
    logic [CW-1:0]    r_count = '0;
    logic [1:0]       r_error = ER_NONE;
    logic [WIDTH-1:0] r_mem [MAX];

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_cnt_m1;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(MAX));
    assign w_cnt_m1 = r_count - CW'(1);

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_count[AW-1:0];
        if (!reset) begin
            if (op == OP_PUSH && !w_full) begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_count[AW-1:0];
            end else if (op == OP_REPLACE && !w_empty) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_cnt_m1[AW-1:0];
            end
        end
    end

    // Storage is not cleared by reset; entries above the count are unreachable.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_error <= ER_NONE;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (w_full) begin
                        r_error <= ER_OVERFLOW;
                    end else begin
                        r_count <= r_count + CW'(1);
                        r_error <= ER_NONE;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_error <= ER_UNDERFLOW;
                    end else begin
                        r_count <= w_cnt_m1;
                        r_error <= ER_NONE;
                    end
                end
                OP_REPLACE: begin
                    r_error <= w_empty ? ER_UNDERFLOW : ER_NONE;
                end
                default: begin
                    r_error <= ER_NONE;
                end
            endcase
        end
    end

    assign tos    = w_empty ? '0 : r_mem[w_cnt_m1[AW-1:0]];
    assign status = w_empty ? ST_EMPTY : (w_full ? ST_FULL : ST_NONE);
    assign error  = r_error;

endmodule

// File: tb/tb_stack.sv
// Scoreboard bench for stack: stimulus pushes expected results from a queue-based
// LIFO model; a monitor pops and compares after every rising edge.
module tb_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 1;
    localparam int MAX   = (1 << (DEPTH + 1)) - 1;

    localparam logic [1:0] NONE = 2'b00, PUSH = 2'b01, POP = 2'b10, REPLACE = 2'b11;
    localparam logic [1:0] EMPTY = 2'b01, FULL = 2'b10;
    localparam logic [1:0] UNDERFLOW = 2'b01, OVERFLOW = 2'b10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       op = NONE;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] tos;
    logic [1:0]       status;
    logic [1:0]       error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [WIDTH-1:0] tos;
        logic [1:0]       status;
        logic [1:0]       error;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] mdl[$];
    logic [1:0]       m_err = NONE;

    stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op(op), .data(data),
        .tos(tos), .status(status), .error(error)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_now();
        exp_t e;
        e.tos    = (mdl.size() > 0) ? mdl[mdl.size()-1] : '0;
        e.status = (mdl.size() == 0) ? EMPTY : ((mdl.size() == MAX) ? FULL : NONE);
        e.error  = m_err;
        return e;
    endfunction

    task automatic model_apply(input logic [1:0] o, input logic [WIDTH-1:0] d);
        case (o)
            PUSH: begin
                if (mdl.size() < MAX) begin mdl.push_back(d); m_err = NONE; end
                else m_err = OVERFLOW;
            end
            POP: begin
                if (mdl.size() > 0) begin void'(mdl.pop_back()); m_err = NONE; end
                else m_err = UNDERFLOW;
            end
            REPLACE: begin
                if (mdl.size() > 0) begin mdl[mdl.size()-1] = d; m_err = NONE; end
                else m_err = UNDERFLOW;
            end
            default: m_err = NONE;
        endcase
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".tos"}, tos, e.tos);
        check({tag, ".status"}, WIDTH'(status), WIDTH'(e.status));
        check({tag, ".error"}, WIDTH'(error), WIDTH'(e.error));
    endtask

    task automatic step(input logic [1:0] o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        op   = o;
        data = d;
        model_apply(o, d);
        exp_q.push_back(model_now());
    endtask

    // Reset raised between edges must take effect immediately; an op held
    // across the following edge must be ignored.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #2 reset = 1'b1;
        mdl.delete();
        m_err = NONE;
        #1;
        e = model_now();
        check_all("async_reset", e);
        op   = PUSH;
        data = WIDTH'($urandom_range(0, 255));
        exp_q.push_back(model_now());
        @(negedge clk);
        reset = 1'b0;
        op    = NONE;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("cycle", e);
            end
        end
    end

    initial begin : stimulus
        int budget;
        #1;
        check_all("power_on", model_now());

        step(POP, 8'h00);
        step(PUSH, 8'h00);
        step(PUSH, 8'h01);
        step(PUSH, 8'h02);
        step(NONE, 8'h00);
        step(PUSH, 8'h03);
        step(NONE, 8'h00);
        step(POP, 8'h00);
        step(POP, 8'h00);
        step(POP, 8'h00);
        step(REPLACE, 8'h04);
        step(PUSH, 8'h05);
        step(REPLACE, 8'h06);
        step(NONE, 8'h00);
        do_reset();
        step(PUSH, 8'h07);
        step(NONE, 8'h00);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else step(2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 255)));
        end

        @(negedge clk);
        op = NONE;
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
